// File: rtl/rx_port_arbiter_if.sv
// Read-side bus between the four RX frame FIFOs, rx_port_arbiter and MAC_DEC.
// master = arbiter side, slave = FIFO/decoder side.
interface rx_port_arbiter_if;
  logic [31:0] i_fifo_dout;
  logic [3:0]  i_fifo_empty;
  logic [3:0]  i_fifo_del;
  logic [3:0]  i_fifo_rden;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_sof;
  logic        o_eof;
  logic        o_abort;
  logic [1:0]  o_port;
  logic        busy;

  modport master (
    input  i_fifo_dout, i_fifo_empty, i_fifo_del, o_ready,
    output i_fifo_rden, o_data, o_valid, o_sof, o_eof, o_abort, o_port, busy
  );

  modport slave (
    output i_fifo_dout, i_fifo_empty, i_fifo_del, o_ready,
    input  i_fifo_rden, o_data, o_valid, o_sof, o_eof, o_abort, o_port, busy
  );
endinterface

// File: rtl/rx_port_arbiter.sv
// Frame-granular round-robin arbiter draining four RX frame FIFOs into MAC_DEC.
// Optional per-frame length watchdog: define RX_ARB_WDOG_EN.
module rx_port_arbiter #(
  parameter int unsigned PORT_NUM = 4,
  parameter int unsigned MAX_LEN  = 1522,
  parameter int unsigned CNT_W    = 11
) (
  input logic               clk,
  input logic               arst_n,
  rx_port_arbiter_if.master bus
);

`ifdef RX_ARB_WDOG_EN
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
`else
  typedef enum logic [0:0] {IDLE, XFER} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  gnt_q;
  logic [1:0]  pick;
  logic [1:0]  cand;
  logic        found;
  logic        rd_pend_q;
  logic        eod_seen_q;
  logic        first_q;
  logic [3:0]  rden;
  logic [7:0]  cur_byte;
  logic        cur_del;

  logic [7:0]  data_q;
  logic        valid_q;
  logic        sof_q;
  logic        eof_q;
  logic [1:0]  port_q;
  logic        busy_q;

`ifdef RX_ARB_WDOG_EN
  logic [CNT_W-1:0] byte_cnt_q;
  logic             abort_q;
  logic             wdog_hit;

  // Returning byte would be the MAX_LEN'th of the frame without an end marker.
  assign wdog_hit = rd_pend_q && !cur_del && (byte_cnt_q == CNT_W'(MAX_LEN - 1));
  assign bus.o_abort = abort_q;
`else
  logic [31:0] unused_cfg;

  // Keeps the watchdog sizing parameters referenced when the watchdog is compiled out.
  assign unused_cfg  = MAX_LEN ^ CNT_W;
  assign bus.o_abort = 1'b0;
`endif

  assign cur_byte = bus.i_fifo_dout[{gnt_q, 3'b000} +: 8];
  assign cur_del  = bus.i_fifo_del[gnt_q];

  // Search order starts just after the last granted port, so it ends up last.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = '0;
    for (int unsigned i = 1; i <= PORT_NUM; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (!found && !bus.i_fifo_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // A read is never issued while the previous byte's end marker is still unchecked.
  always_comb begin
    state_d = state_q;
    rden    = '0;
    case (state_q)
      IDLE: begin
        if (found) state_d = XFER;
      end
      XFER: begin
        if (eod_seen_q) begin
          state_d = IDLE;
`ifdef RX_ARB_WDOG_EN
        end else if (wdog_hit) begin
          state_d = DRAIN;
`endif
        end else if (!rd_pend_q && bus.o_ready && !bus.i_fifo_empty[gnt_q]) begin
          rden[gnt_q] = 1'b1;
        end
      end
`ifdef RX_ARB_WDOG_EN
      DRAIN: begin
        if (rd_pend_q && cur_del) begin
          state_d = IDLE;
        end else if (!rd_pend_q && !bus.i_fifo_empty[gnt_q]) begin
          rden[gnt_q] = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_ptr_q   <= 2'd3;
      gnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      eod_seen_q <= 1'b0;
      first_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      port_q     <= '0;
      busy_q     <= 1'b0;
`ifdef RX_ARB_WDOG_EN
      byte_cnt_q <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      rd_pend_q <= |rden;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
`ifdef RX_ARB_WDOG_EN
      abort_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_q      <= pick;
            rr_ptr_q   <= pick;
            port_q     <= pick;
            busy_q     <= 1'b1;
            eod_seen_q <= 1'b0;
            first_q    <= 1'b1;
`ifdef RX_ARB_WDOG_EN
            byte_cnt_q <= '0;
`endif
          end
        end
        XFER: begin
          if (eod_seen_q) begin
            busy_q <= 1'b0;
          end else if (rd_pend_q) begin
            valid_q    <= 1'b1;
            data_q     <= cur_byte;
            sof_q      <= first_q;
            first_q    <= 1'b0;
            eod_seen_q <= cur_del;
`ifdef RX_ARB_WDOG_EN
            eof_q      <= cur_del | wdog_hit;
            abort_q    <= wdog_hit;
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
`else
            eof_q      <= cur_del;
`endif
          end
        end
`ifdef RX_ARB_WDOG_EN
        DRAIN: begin
          if (rd_pend_q && cur_del) busy_q <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.i_fifo_rden = rden;
  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_sof       = sof_q;
  assign bus.o_eof       = eof_q;
  assign bus.o_port      = port_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Directed bench for rx_port_arbiter: FIFO read-side model plus output/read scoreboards.
// Define RX_ARB_WDOG_EN for both DUT and bench to add the watchdog scenario (MAX_LEN=100).
module tb_rx_port_arbiter;
`ifdef RX_ARB_WDOG_EN
  localparam int unsigned MAX_LEN = 100;
`else
  localparam int unsigned MAX_LEN = 1522;
`endif

  typedef struct packed {
    logic       abort;
    logic       eof;
    logic       sof;
    logic [1:0] port;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  rx_port_arbiter_if bus ();

  rx_port_arbiter #(.PORT_NUM(4), .MAX_LEN(MAX_LEN), .CNT_W(11)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  logic [8:0]  fq [4][$];
  beat_t       sb [$];
  logic [1:0]  rd_exp [$];
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned valid_cnt = 0;
  int unsigned last_eof_cyc = 0;
  bit          gap_armed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_push(input int p, input logic [7:0] start, input int first, input int n, input int total);
    for (int i = first; i < first + n; i++)
      fq[p].push_back({(i == total - 1), 8'(start + 8'(i))});
  endtask

  // abort_at = 0: full frame delivered; otherwise only abort_at beats, last one aborted.
  task automatic expect_frame(input int p, input logic [7:0] start, input int total, input int abort_at);
    int n;
    n = (abort_at == 0) ? total : abort_at;
    for (int i = 0; i < n; i++)
      sb.push_back(beat_t'({(abort_at != 0) && (i == n - 1), (i == n - 1), (i == 0),
                            2'(p), 8'(start + 8'(i))}));
    for (int i = 0; i < total; i++) rd_exp.push_back(2'(p));
  endtask

  task automatic wait_busy(input string tag);
    int unsigned n = 0;
    while (!bus.busy && n < 50) begin @(negedge clk); n++; end
    chk(tag, bus.busy, 1);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_beats_left"}, sb.size(), 0);
    chk({tag, "_reads_left"}, rd_exp.size(), 0);
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [18:0] out_vec();
    return {bus.o_data, bus.o_valid, bus.o_sof, bus.o_eof, bus.o_abort,
            bus.o_port, bus.busy, bus.i_fifo_rden};
  endfunction

  initial begin
    int unsigned v0;
    arst_n           = 1'b0;
    bus.o_ready      = 1'b1;
    bus.i_fifo_dout  = '0;
    bus.i_fifo_del   = '0;
    bus.i_fifo_empty = '1;

    fork
      begin : fifo_model
        logic [8:0] w;
        forever begin
          @(posedge clk);
          for (int p = 0; p < 4; p++) begin
            if (bus.i_fifo_rden[p] && fq[p].size() > 0) begin
              w = fq[p].pop_front();
              bus.i_fifo_dout[8*p +: 8] <= w[7:0];
              bus.i_fifo_del[p]         <= w[8];
            end
            bus.i_fifo_empty[p] <= (fq[p].size() == 0);
          end
        end
      end
      begin : monitor
        logic [3:0] prev_rden;
        bit         prev_eof;
        beat_t      e;
        prev_rden = '0;
        prev_eof  = 1'b0;
        forever begin
          @(negedge clk);
          cyc++;
          if (!arst_n) begin
            prev_rden = '0;
            prev_eof  = 1'b0;
          end else begin
            if (bus.i_fifo_rden != 4'd0) begin
              if (rd_exp.size() == 0) chk("rd_unexpected", bus.i_fifo_rden, 0);
              else chk("rd_port", bus.i_fifo_rden, 32'(1) << rd_exp.pop_front());
              chk("rd_cadence", prev_rden, 0);
              chk("rd_while_ready", bus.o_ready, 1);
            end
            prev_rden = bus.i_fifo_rden;
            if (prev_eof) chk("busy_after_eof", bus.busy, 0);
            prev_eof = bus.o_valid && bus.o_eof && !bus.o_abort;
            if (bus.o_valid) begin
              valid_cnt++;
              chk("busy_in_frame", bus.busy, 1);
              if (sb.size() == 0) chk("valid_unexpected", bus.o_valid, 0);
              else begin
                e = sb.pop_front();
                chk("beat", {bus.o_abort, bus.o_eof, bus.o_sof, bus.o_port, bus.o_data}, 32'(e));
              end
              if (bus.o_sof && gap_armed) chk("frame_gap", cyc - last_eof_cyc, 4);
              if (bus.o_eof) begin
                last_eof_cyc = cyc;
                gap_armed    = !bus.o_abort;
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", out_vec(), 0);
    step();
    arst_n = 1'b1;
    repeat (3) step();

    // Single 64-byte frame on port 2
    gap_armed = 1'b0;
    fifo_push(2, 8'h00, 0, 64, 64);
    expect_frame(2, 8'h00, 64, 0);
    wait_idle("t1", 1000);

    // Reset again so the round-robin pointer restarts at 3
    step();
    arst_n = 1'b0;
    @(negedge clk);
    chk("rst2_outputs", out_vec(), 0);
    step();
    arst_n = 1'b1;
    repeat (2) step();

    // Ports 0, 1, 3 loaded together
    gap_armed = 1'b0;
    fifo_push(0, 8'h10, 0, 60, 60);
    fifo_push(1, 8'h50, 0, 60, 60);
    fifo_push(3, 8'h90, 0, 60, 60);
    expect_frame(0, 8'h10, 60, 0);
    expect_frame(1, 8'h50, 60, 0);
    expect_frame(3, 8'h90, 60, 0);
    wait_idle("t2", 2000);

    // Fairness: port 1 with two frames, port 0 arrives after port 1's grant
    step();
    gap_armed = 1'b0;
    fifo_push(1, 8'h20, 0, 30, 30);
    fifo_push(1, 8'hA0, 0, 25, 25);
    expect_frame(1, 8'h20, 30, 0);
    wait_busy("t3_grant");
    fifo_push(0, 8'h60, 0, 20, 20);
    expect_frame(0, 8'h60, 20, 0);
    expect_frame(1, 8'hA0, 25, 0);
    wait_idle("t3", 2000);

    // Back-pressure mid-frame on port 2
    step();
    gap_armed = 1'b0;
    v0 = valid_cnt;
    fifo_push(2, 8'hC0, 0, 40, 40);
    expect_frame(2, 8'hC0, 40, 0);
    for (int n = 0; n < 200 && valid_cnt < v0 + 10; n++) @(negedge clk);
    chk("t4_reach_mid", valid_cnt - v0, 10);
    step();
    bus.o_ready = 1'b0;
    v0 = valid_cnt;
    repeat (20) step();
    chk("t4_ready_low_beats", (valid_cnt - v0) <= 1, 1);
    bus.o_ready = 1'b1;
    wait_idle("t4", 1000);

    // Port 3 starves mid-frame while port 0 waits
    step();
    gap_armed = 1'b0;
    fifo_push(3, 8'h80, 0, 10, 30);
    expect_frame(3, 8'h80, 30, 0);
    wait_busy("t5_grant");
    v0 = valid_cnt;
    fifo_push(0, 8'h40, 0, 20, 20);
    expect_frame(0, 8'h40, 20, 0);
    repeat (100) step();
    chk("t5_hold_busy", bus.busy, 1);
    chk("t5_partial_beats", valid_cnt - v0, 10);
    chk("t5_port0_untouched", fq[0].size(), 20);
    fifo_push(3, 8'h80, 10, 20, 30);
    wait_idle("t5", 1000);

`ifdef RX_ARB_WDOG_EN
    // Over-length frame is cut at MAX_LEN, remainder drained silently
    step();
    gap_armed = 1'b0;
    fifo_push(0, 8'h00, 0, 150, 150);
    fifo_push(0, 8'hA0, 0, 60, 60);
    expect_frame(0, 8'h00, 150, 100);
    expect_frame(0, 8'hA0, 60, 0);
    wait_idle("t6", 3000);
`endif

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
